// File: rtl/can_tx_framer_if.sv
// can_tx_framer_if
//   Transmit-request bundle between the AHB CAN front-end (master) and the
//   CAN transmit framer (slave).
//
//   Handshake: startXmit is a one-cycle request. The framer takes it only
//   while busy is low; on that edge every field of the bundle is captured.
//   busy rises the following cycle and stays high until the last
//   intermission bit has ended (or arbitration is lost). A request made
//   while busy is high is dropped, not queued.
//
//   Signals: startXmit, xmitdata[63:0], quantaDiv[7:0], propQuanta[5:0],
//            seg1Quanta[5:0], datalen[3:0], format, frameType[1:0],
//            id[28:0] (master -> slave); busy (slave -> master).
interface can_tx_framer_if;
  logic        startXmit;
  logic [63:0] xmitdata;
  logic [7:0]  quantaDiv;
  logic [5:0]  propQuanta;
  logic [5:0]  seg1Quanta;
  logic [3:0]  datalen;
  logic        format;
  logic [1:0]  frameType;
  logic [28:0] id;
  logic        busy;

  modport master (
    output startXmit, xmitdata, quantaDiv, propQuanta, seg1Quanta,
           datalen, format, frameType, id,
    input  busy
  );

  modport slave (
    input  startXmit, xmitdata, quantaDiv, propQuanta, seg1Quanta,
           datalen, format, frameType, id,
    output busy
  );
endinterface

// File: rtl/can_tx_framer.sv
// can_tx_framer
//   Builds a CAN 2.0A/2.0B data/remote frame (or an error/overload frame),
//   bit-stuffs it, appends CRC-15 and times every bit from the programmed
//   time quanta. Checks arbitration and the ACK slot on the sampled bus.
//
//   Ports:
//     HCLK, HRESET    clock, asynchronous active-low reset
//     req             transmit-request bundle (can_tx_framer_if.slave)
//     can_tx          bus drive, 1 = recessive
//     can_rx          bus sample
//     tx_done         one-cycle pulse, frame completed with ACK
//     arb_lost        one-cycle pulse, arbitration lost
//     ack_err         one-cycle pulse, ACK slot sampled recessive
//     state_dbg       current field state
//
//   Parameters: SEG2_QUANTA (phase segment 2, quanta), IFS_BITS.
//   Build option: CAN_TX_LOOPBACK_EN samples can_tx instead of can_rx and
//   treats the ACK slot as dominant.
module can_tx_framer #(
  parameter int SEG2_QUANTA = 2,
  parameter int IFS_BITS    = 3
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  can_tx_framer_if.slave        req,
  output logic                  can_tx,
  input  logic                  can_rx,
  output logic                  tx_done,
  output logic                  arb_lost,
  output logic                  ack_err,
  output logic [3:0]            state_dbg
);
  typedef enum logic [3:0] {
    S_IDLE, S_SOF, S_ARB, S_CTRL, S_DATA, S_CRC, S_CRC_DEL,
    S_ACK_SLOT, S_ACK_DEL, S_EOF, S_IFS, S_ERRF
  } state_t;

  state_t      state, nxt_state, pos_state;
  logic [6:0]  bit_idx, nxt_idx, pos_idx, field_len, data_bits;
  logic [7:0]  presc, qcnt, samp_at, end_at;
  logic [2:0]  run_len;
  logic        is_stuff, ack_bad;
  logic [14:0] crc, crc_nxt;

  // request fields captured at acceptance
  logic [28:0] id_q;
  logic [63:0] data_q;
  logic [3:0]  dlc_q;
  logic        ext_q, rtr_q;
  logic [7:0]  div_q;
  logic [5:0]  prop_q, seg1_q;

  logic tick, smp_pt, bit_end, field_last, field_bit, need_stuff, tx_nxt;
  logic in_stuff_zone, in_crc_zone, smp_val, arb_hit, ack_hit;

  assign state_dbg = state;
  assign req.busy  = (state != S_IDLE);

  // Quantum index 0 is sync, then prop, then seg1; the sample point is the
  // end of the last seg1 quantum, the bit ends after SEG2_QUANTA more.
  assign samp_at = {2'b00, prop_q} + {2'b00, seg1_q};
  assign end_at  = samp_at + 8'(SEG2_QUANTA);
  assign tick    = (presc == div_q);
  assign smp_pt  = tick && (qcnt == samp_at);
  assign bit_end = tick && (qcnt == end_at);

  assign in_stuff_zone = (state == S_SOF) || (state == S_ARB) || (state == S_CTRL) ||
                         (state == S_DATA) || (state == S_CRC);
  assign in_crc_zone   = (state == S_SOF) || (state == S_ARB) || (state == S_CTRL) ||
                         (state == S_DATA);

`ifdef CAN_TX_LOOPBACK_EN
  assign smp_val = can_tx;
  assign ack_hit = 1'b0;  // own ACK slot counts as dominant
`else
  assign smp_val = can_rx;
  assign ack_hit = (state == S_ACK_SLOT) && smp_val;
`endif
  // Stuff bits are never arbitration-checked.
  assign arb_hit = (state == S_ARB) && !is_stuff && can_tx && !smp_val;

  always_comb begin
    data_bits = 7'd0;
    if (!rtr_q && dlc_q != 4'd0) data_bits = (dlc_q > 4'd8) ? 7'd64 : {dlc_q, 3'b000};
  end

  always_comb begin
    field_len = 7'd1;
    case (state)
      S_ARB:   field_len = ext_q ? 7'd32 : 7'd12;
      S_CTRL:  field_len = 7'd6;
      S_DATA:  field_len = data_bits;
      S_CRC:   field_len = 7'd15;
      S_EOF:   field_len = 7'd7;
      S_IFS:   field_len = 7'(IFS_BITS);
      S_ERRF:  field_len = 7'd14;
      default: field_len = 7'd1;
    endcase
  end
  assign field_last = (bit_idx == field_len - 7'd1);

  // Position of the next real (unstuffed) bit.
  always_comb begin
    nxt_state = state;
    nxt_idx   = bit_idx + 7'd1;
    if (field_last) begin
      nxt_idx = 7'd0;
      case (state)
        S_SOF:      nxt_state = S_ARB;
        S_ARB:      nxt_state = S_CTRL;
        S_CTRL:     nxt_state = (data_bits != 7'd0) ? S_DATA : S_CRC;
        S_DATA:     nxt_state = S_CRC;
        S_CRC:      nxt_state = S_CRC_DEL;
        S_CRC_DEL:  nxt_state = S_ACK_SLOT;
        S_ACK_SLOT: nxt_state = S_ACK_DEL;
        S_ACK_DEL:  nxt_state = S_EOF;
        S_EOF:      nxt_state = S_IFS;
        S_ERRF:     nxt_state = S_IFS;
        default:    nxt_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    crc_nxt = crc;
    if (!is_stuff && in_crc_zone)
      crc_nxt = {crc[13:0], 1'b0} ^ ((can_tx ^ crc[14]) ? 15'h4599 : 15'h0000);
  end

  // The position pointer is advanced at the end of every real bit, so after
  // a stuff bit the pending field bit is the one already pointed at.
  always_comb begin
    pos_state = is_stuff ? state : nxt_state;
    pos_idx   = is_stuff ? bit_idx : nxt_idx;
    field_bit = 1'b1;
    case (pos_state)
      S_SOF: field_bit = 1'b0;
      S_ARB: begin
        if (pos_idx < 7'd11)       field_bit = id_q[5'd28 - pos_idx[4:0]];
        else if (!ext_q)           field_bit = rtr_q;
        else if (pos_idx < 7'd13)  field_bit = 1'b1;                       // SRR, IDE
        else if (pos_idx < 7'd31)  field_bit = id_q[5'd30 - pos_idx[4:0]]; // id[17:0]
        else                       field_bit = rtr_q;
      end
      S_CTRL: begin
        case (pos_idx[2:0])
          3'd2:    field_bit = dlc_q[3];
          3'd3:    field_bit = dlc_q[2];
          3'd4:    field_bit = dlc_q[1];
          3'd5:    field_bit = dlc_q[0];
          default: field_bit = 1'b0;  // IDE/r1 and r0
        endcase
      end
      S_DATA:  field_bit = data_q[6'd63 - pos_idx[5:0]];
      S_CRC:   field_bit = crc_nxt[4'd14 - pos_idx[3:0]];
      S_ERRF:  field_bit = (pos_idx >= 7'd6);
      default: field_bit = 1'b1;
    endcase
  end

  assign need_stuff = !is_stuff && in_stuff_zone && (run_len == 3'd5);
  assign tx_nxt     = need_stuff ? ~can_tx : field_bit;

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state    <= S_IDLE;
      bit_idx  <= '0;
      presc    <= '0;
      qcnt     <= '0;
      run_len  <= '0;
      is_stuff <= 1'b0;
      ack_bad  <= 1'b0;
      crc      <= '0;
      id_q     <= '0;
      data_q   <= '0;
      dlc_q    <= '0;
      ext_q    <= 1'b0;
      rtr_q    <= 1'b0;
      div_q    <= '0;
      prop_q   <= '0;
      seg1_q   <= '0;
      can_tx   <= 1'b1;
      tx_done  <= 1'b0;
      arb_lost <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      arb_lost <= 1'b0;
      ack_err  <= 1'b0;
      if (state == S_IDLE) begin
        can_tx <= 1'b1;
        if (req.startXmit) begin
          id_q     <= req.id;
          data_q   <= req.xmitdata;
          dlc_q    <= req.datalen;
          ext_q    <= req.format;
          rtr_q    <= (req.frameType == 2'b01);
          div_q    <= req.quantaDiv;
          prop_q   <= req.propQuanta;
          seg1_q   <= req.seg1Quanta;
          presc    <= '0;
          qcnt     <= '0;
          bit_idx  <= '0;
          is_stuff <= 1'b0;
          run_len  <= 3'd1;
          crc      <= '0;
          ack_bad  <= 1'b0;
          can_tx   <= 1'b0;  // SOF, or first dominant bit of an error/overload flag
          state    <= req.frameType[1] ? S_ERRF : S_SOF;
        end
      end else begin
        presc <= tick ? 8'd0 : presc + 8'd1;
        if (tick) qcnt <= (qcnt == end_at) ? 8'd0 : qcnt + 8'd1;
        if (smp_pt && arb_hit) begin
          state    <= S_IDLE;
          can_tx   <= 1'b1;
          arb_lost <= 1'b1;
        end else begin
          if (smp_pt && ack_hit) begin
            ack_err <= 1'b1;
            ack_bad <= 1'b1;
          end
          if (bit_end) begin
            crc      <= crc_nxt;
            is_stuff <= need_stuff;
            can_tx   <= tx_nxt;
            run_len  <= (tx_nxt != can_tx) ? 3'd1 : (run_len == 3'd7) ? 3'd7 : run_len + 3'd1;
            if (!is_stuff) begin
              state   <= nxt_state;
              bit_idx <= nxt_idx;
              if (nxt_state == S_IDLE) tx_done <= !ack_bad;
            end
          end
        end
      end
    end
  end
endmodule
